echo_queue: RTL

- Parametrised successor to the single-entry echo block.
- Buffers up to DEPTH request messages from two request methods (say, say2) in an in-order FIFO.
- Holds each message in a delay stage for a programmable number of cycles, then replays it on the heard indication with a RDY/ENA handshake.
- say2 messages are echoed twice. The block sits between a request portal and an indication portal; the enclosing scheduler drives the two internal rules through rule_enable/rule_ready.

---
 rtl/echo_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/echo_queue.sv
// rtl/echo_queue.sv - in-order echo FIFO with a programmable delay stage and say2 double replay
// Entries are {rep, meth, v}; the stage replays each entry once (say) or twice (say2).
module echo_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int DELAY_CYCLES = 1
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          request_say__ENA,
  input  logic [DATA_WIDTH-1:0]         request_say_meth,
  input  logic [DATA_WIDTH-1:0]         request_say_v,
  output logic                          request_say__RDY,
  input  logic                          request_say2__ENA,
  input  logic [DATA_WIDTH-1:0]         request_say2_meth,
  input  logic [DATA_WIDTH-1:0]         request_say2_v,
  output logic                          request_say2__RDY,
  output logic                          indication_heard__ENA,
  output logic [DATA_WIDTH-1:0]         indication_heard_meth,
  output logic [DATA_WIDTH-1:0]         indication_heard_v,
  input  logic                          indication_heard__RDY,
  input  logic [1:0]                    rule_enable,
  output logic [1:0]                    rule_ready,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int TMR_W = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES+1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DELAY_CYCLES);

  logic                  r_mem_rep  [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_meth [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_v    [DEPTH];

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_stage_valid;
  logic [DATA_WIDTH-1:0] r_stage_meth;
  logic [DATA_WIDTH-1:0] r_stage_v;
  logic [1:0]            r_stage_remaining;
  logic [TMR_W-1:0]      r_timer;

  logic                  w_not_full;
  logic                  w_say_acc;
  logic                  w_say2_acc;
  logic                  w_push;
  logic                  w_wr_rep;
  logic [DATA_WIDTH-1:0] w_wr_meth;
  logic [DATA_WIDTH-1:0] w_wr_v;
  logic                  w_delay_ready;
  logic                  w_resp_ready;
  logic                  w_delay_fire;
  logic                  w_resp_fire;

  // say wins a same-cycle collision, so say2 is only accepted when say is idle
  assign w_not_full        = (r_count != FULL_CNT);
  assign request_say__RDY  = w_not_full;
  assign request_say2__RDY = w_not_full && !request_say__ENA;
  assign w_say_acc         = request_say__ENA && request_say__RDY;
  assign w_say2_acc        = request_say2__ENA && request_say2__RDY;
  assign w_push            = w_say_acc || w_say2_acc;
  assign w_wr_rep          = !w_say_acc;
  assign w_wr_meth         = w_say_acc ? request_say_meth : request_say2_meth;
  assign w_wr_v            = w_say_acc ? request_say_v    : request_say2_v;

  assign w_delay_ready = (r_count != '0) && !r_stage_valid;
  assign w_resp_ready  = r_stage_valid && (r_timer == '0) && indication_heard__RDY;
  assign w_delay_fire  = rule_enable[0] && w_delay_ready;
  assign w_resp_fire   = rule_enable[1] && w_resp_ready;

  assign rule_ready            = {w_resp_ready, w_delay_ready};
  assign indication_heard__ENA = w_resp_fire;
  assign indication_heard_meth = r_stage_valid ? r_stage_meth : '0;
  assign indication_heard_v    = r_stage_valid ? r_stage_v    : '0;
  assign occupancy             = r_count;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_rep[r_wptr]  <= w_wr_rep;
      r_mem_meth[r_wptr] <= w_wr_meth;
      r_mem_v[r_wptr]    <= w_wr_v;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_count           <= '0;
      r_stage_valid     <= 1'b0;
      r_stage_meth      <= '0;
      r_stage_v         <= '0;
      r_stage_remaining <= 2'd0;
      r_timer           <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_delay_fire) r_rptr <= r_rptr + 1'b1;

      if (w_push && !w_delay_fire) r_count <= r_count + 1'b1;
      else if (!w_push && w_delay_fire) r_count <= r_count - 1'b1;

      // delay and respond never fire together: one needs the stage empty, the other full
      if (w_delay_fire) begin
        r_stage_valid     <= 1'b1;
        r_stage_meth      <= r_mem_meth[r_rptr];
        r_stage_v         <= r_mem_v[r_rptr];
        r_stage_remaining <= r_mem_rep[r_rptr] ? 2'd2 : 2'd1;
        r_timer           <= TMR_LOAD;
      end else if (w_resp_fire) begin
        if (r_stage_remaining == 2'd2) begin
          r_stage_remaining <= 2'd1;
          r_timer           <= TMR_LOAD;
        end else begin
          r_stage_valid     <= 1'b0;
        end
      end else if (r_stage_valid && (r_timer != '0)) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

endmodule
